dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL run on a single clock and use an asynchronous, active-high reset.
REQ-002 The block SHALL have these ports, clock and reset first:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- {a,b}_req  input  1  access request; port a = CPU load/store, port b = serial loader/DMA
- {a,b}_we  input  1  1 = write, 0 = read
- {a,b}_size  input  2  access size (00 byte, 01 half, 11 word), passed through to memory
- {a,b}_addr  input  32  byte address
- {a,b}_wdata  input  32  write data
- {a,b}_gnt  output  1  access issued to memory this cycle
- {a,b}_rvalid  output  1  read data valid this cycle
- {a,b}_rdata  output  32  read data
- a_stall  output  1  CPU must hold its PC and pipeline this cycle
- mem_addr / mem_wdata  output  32  to data_memory addr_in / writedata_in
- mem_re / mem_we  output  1  to data_memory re_in / we_in
- mem_size  output  2  to data_memory size_in
- mem_rdata  input  32  from data_memory readdata_out; valid one cycle after mem_re
REQ-003 The block SHALL have no parameters.

Function
REQ-004 The FSM SHALL have two states, IDLE and READ_WAIT, plus a 1-bit last_grant register (0 = a, 1 = b) and a 1-bit owner register.
REQ-005 In IDLE with exactly one request active, that port SHALL win.
REQ-006 In IDLE with both requests active, the port not equal to last_grant SHALL win (round-robin).
REQ-007 In IDLE, the winner's gnt SHALL assert combinationally in the same cycle.
- mem_addr, mem_wdata, mem_size and mem_we/mem_re SHALL come from the winner.
- last_grant SHALL update to the winner at the next edge.
REQ-008 A granted write SHALL complete in its grant cycle; the FSM SHALL stay in IDLE.
REQ-009 A granted read SHALL assert mem_re for one cycle, record owner, and move to READ_WAIT.
REQ-010 In READ_WAIT:
- owner's rvalid = 1 and owner's rdata = mem_rdata;
- no gnt, mem_re or mem_we;
- next state IDLE unconditionally.
REQ-011 Throughput SHALL be one write per cycle or one read per two cycles; a port SHALL never be granted two consecutive accesses while the other port requests, except as REQ-019 allows.
REQ-012 Whenever rvalid is 0, rdata SHALL be 0; with no grant, mem_* outputs SHALL be 0.
REQ-013 a_stall SHALL equal a_req & ~((a_gnt & a_we) | a_rvalid).
REQ-014 Requesters SHALL hold req/we/size/addr/wdata stable until write-gnt or rvalid; the arbiter does not latch request fields.
REQ-015 A req deasserted while its read is in READ_WAIT SHALL still produce the rvalid pulse.

Reset
REQ-016 Asynchronous reset SHALL force state IDLE, last_grant = 1 (port a wins first conflict) and owner = 0.
- All gnt, rvalid, mem_re and mem_we SHALL be 0 during reset.
REQ-017 Reset asserted during READ_WAIT SHALL abort the read; no rvalid SHALL be produced after reset release.

Configuration
REQ-018 Macro DMEM_ARB_LOCK_EN SHALL compile in input b_lock (1 bit).
REQ-019 With DMEM_ARB_LOCK_EN defined, a conflict in IDLE while b_lock = 1 and last_grant = 1 SHALL be won by port b (burst hold); a_stall stays asserted.
REQ-020 Without DMEM_ARB_LOCK_EN, b_lock SHALL be absent and arbitration SHALL be purely REQ-005/006.

Verification
REQ-021 Reset release, a_req=1, a_we=1, a_addr=0x10, a_wdata=0xDEADBEEF -> same cycle a_gnt=1, mem_we=1, mem_addr=0x10, a_stall=0.
REQ-022 a read 0x10 with memory returning 0xDEADBEEF -> cycle0 a_gnt=1, mem_re=1, a_stall=1; cycle1 a_rvalid=1, a_rdata=0xDEADBEEF, a_stall=0.
REQ-023 a and b both request writes continuously after reset -> grants alternate a,b,a,b on consecutive cycles.
REQ-024 a read granted, b_req asserted in READ_WAIT -> no grant in READ_WAIT; b_gnt the following cycle.
REQ-025 Reset pulsed in READ_WAIT -> no a_rvalid afterwards; next conflict granted to a.
REQ-026 With DMEM_ARB_LOCK_EN, b_lock=1, both write continuously after b first wins -> b_gnt every cycle, a_stall=1; drop b_lock -> a granted next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU (a) and loader/DMA (b) share one memory port.
// Optional burst-hold for port b is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_size,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_stall,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_size,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic        b_lock,
`endif
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_t;

    state_t state, state_next;
    logic   last_grant, last_grant_next;
    logic   owner, owner_next;
    logic   lock_hold;
    logic   win_b;

`ifdef DMEM_ARB_LOCK_EN
    assign lock_hold = b_lock & last_grant;
`else
    assign lock_hold = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            owner      <= owner_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        owner_next      = owner;
        win_b           = 1'b0;
        a_gnt           = 1'b0;
        b_gnt           = 1'b0;
        a_rvalid        = 1'b0;
        b_rvalid        = 1'b0;
        a_rdata         = '0;
        b_rdata         = '0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_re          = 1'b0;
        mem_we          = 1'b0;
        mem_size        = '0;
        // Reset gates the combinational grant path so nothing reaches memory while held.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        win_b           = b_req & (~a_req | ~last_grant | lock_hold);
                        last_grant_next = win_b;
                        if (win_b) begin
                            b_gnt     = 1'b1;
                            mem_addr  = b_addr;
                            mem_wdata = b_wdata;
                            mem_size  = b_size;
                            mem_we    = b_we;
                            mem_re    = ~b_we;
                        end else begin
                            a_gnt     = 1'b1;
                            mem_addr  = a_addr;
                            mem_wdata = a_wdata;
                            mem_size  = a_size;
                            mem_we    = a_we;
                            mem_re    = ~a_we;
                        end
                        if (mem_re) begin
                            state_next = READ_WAIT;
                            owner_next = win_b;
                        end
                    end
                end
                READ_WAIT: begin
                    state_next = IDLE;
                    if (owner) begin
                        b_rvalid = 1'b1;
                        b_rdata  = mem_rdata;
                    end else begin
                        a_rvalid = 1'b1;
                        a_rdata  = mem_rdata;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign a_stall = a_req & ~((a_gnt & a_we) | a_rvalid);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; inputs change on the falling edge, outputs sampled 1ns later.
// Define DMEM_ARB_LOCK_EN for both files to exercise the burst-hold path.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [1:0]  a_size = '0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        a_gnt, a_rvalid, a_stall;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [1:0]  b_size = '0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_gnt, b_rvalid;
    logic [31:0] b_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_re, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    logic        b_lock = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_stall(a_stall),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .b_lock(b_lock),
`endif
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_size(mem_size), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        a_req = req; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        b_req = req; b_we = we; b_size = size; b_addr = addr; b_wdata = wdata;
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    initial begin
        // Reset held: a write request must not reach memory.
        next_cycle();
        drive_a(1, 1, 2'b11, 32'h10, 32'hDEADBEEF);
        #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_gnt", b_gnt, 0);

        // Write immediately after release.
        next_cycle();
        reset = 1'b0;
        #1;
        check("wr_a_gnt", a_gnt, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_re", mem_re, 0);
        check("wr_mem_addr", mem_addr, 32'h10);
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("wr_mem_size", mem_size, 2'b11);
        check("wr_a_stall", a_stall, 0);

        // Read: grant cycle then data cycle.
        next_cycle();
        drive_a(1, 0, 2'b11, 32'h10, 32'h0);
        #1;
        check("rd0_a_gnt", a_gnt, 1);
        check("rd0_mem_re", mem_re, 1);
        check("rd0_mem_we", mem_we, 0);
        check("rd0_a_stall", a_stall, 1);
        check("rd0_a_rdata", a_rdata, 0);
        next_cycle();
        mem_rdata = 32'hDEADBEEF;
        #1;
        check("rd1_a_rvalid", a_rvalid, 1);
        check("rd1_a_rdata", a_rdata, 32'hDEADBEEF);
        check("rd1_a_stall", a_stall, 0);
        check("rd1_a_gnt", a_gnt, 0);
        check("rd1_mem_re", mem_re, 0);
        check("rd1_mem_addr", mem_addr, 0);

        // Fresh reset, then both write continuously: a,b,a,b.
        next_cycle();
        reset = 1'b1;
        drive_a(0, 0, 0, 0, 0);
        mem_rdata = '0;
        next_cycle();
        reset = 1'b0;
        drive_a(1, 1, 2'b11, 32'h100, 32'hAAAA0000);
        drive_b(1, 1, 2'b01, 32'h200, 32'hBBBB0000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            #1;
            check($sformatf("rr%0d_a_gnt", i), a_gnt, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_b_gnt", i), b_gnt, (i % 2 == 1) ? 1 : 0);
            check($sformatf("rr%0d_addr", i), mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            check($sformatf("rr%0d_a_stall", i), a_stall, (i % 2 == 1) ? 1 : 0);
        end

        // b requests during a's READ_WAIT: no grant there, b served next cycle.
        next_cycle();
        drive_a(1, 0, 2'b00, 32'h40, 0);
        drive_b(0, 0, 0, 0, 0);
        #1;
        check("rw_a_gnt", a_gnt, 1);
        check("rw_mem_size", mem_size, 2'b00);
        next_cycle();
        mem_rdata = 32'h12345678;
        drive_b(1, 1, 2'b11, 32'h80, 32'h0000BEEF);
        #1;
        check("rw_b_gnt_wait", b_gnt, 0);
        check("rw_mem_we_wait", mem_we, 0);
        check("rw_a_rvalid", a_rvalid, 1);
        check("rw_a_rdata", a_rdata, 32'h12345678);
        check("rw_b_stall_a", a_stall, 0);
        next_cycle();
        drive_a(0, 0, 0, 0, 0);
        #1;
        check("rw_b_gnt_next", b_gnt, 1);
        check("rw_b_addr", mem_addr, 32'h80);
        check("rw_b_rvalid", b_rvalid, 0);

        // Request dropped during READ_WAIT still gets rvalid.
        next_cycle();
        drive_b(0, 0, 0, 0, 0);
        drive_a(1, 0, 2'b11, 32'h44, 0);
        #1;
        check("drop_a_gnt", a_gnt, 1);
        next_cycle();
        drive_a(0, 0, 0, 0, 0);
        mem_rdata = 32'hCAFEF00D;
        #1;
        check("drop_a_rvalid", a_rvalid, 1);
        check("drop_a_rdata", a_rdata, 32'hCAFEF00D);
        check("drop_a_stall", a_stall, 0);

        // Port b read.
        next_cycle();
        drive_b(1, 0, 2'b01, 32'h88, 0);
        #1;
        check("brd_b_gnt", b_gnt, 1);
        check("brd_mem_re", mem_re, 1);
        check("brd_mem_addr", mem_addr, 32'h88);
        next_cycle();
        mem_rdata = 32'h0BADCAFE;
        #1;
        check("brd_b_rvalid", b_rvalid, 1);
        check("brd_b_rdata", b_rdata, 32'h0BADCAFE);
        check("brd_a_rvalid", a_rvalid, 0);
        check("brd_a_rdata", a_rdata, 0);

        // Reset during READ_WAIT aborts the read; next conflict goes to a.
        next_cycle();
        drive_b(0, 0, 0, 0, 0);
        drive_a(1, 0, 2'b11, 32'h10, 0);
        #1;
        check("abort_a_gnt", a_gnt, 1);
        next_cycle();
        reset = 1'b1;
        mem_rdata = 32'h55555555;
        #1;
        check("abort_rvalid_rst", a_rvalid, 0);
        next_cycle();
        reset = 1'b0;
        drive_a(1, 1, 2'b11, 32'h300, 32'h1);
        drive_b(1, 1, 2'b11, 32'h400, 32'h2);
        #1;
        check("abort_rvalid_after", a_rvalid, 0);
        check("abort_a_first", a_gnt, 1);
        check("abort_b_first", b_gnt, 0);
        next_cycle();
        #1;
        check("abort_b_second", b_gnt, 1);

`ifdef DMEM_ARB_LOCK_EN
        // Burst hold: b keeps the port while b_lock is set.
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        b_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            #1;
            check($sformatf("lock%0d_b_gnt", i), b_gnt, 1);
            check($sformatf("lock%0d_a_stall", i), a_stall, 1);
        end
        next_cycle();
        b_lock = 1'b0;
        #1;
        check("unlock_a_gnt", a_gnt, 1);
        check("unlock_b_gnt", b_gnt, 0);
`endif

        next_cycle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
